// File: rtl/cache_control.sv
// Control FSM for a direct-mapped, write-back L1 cache: hit/miss decision,
// per-set valid/dirty tracking, and writeback/fill sequencing with physical memory.
module cache_control #(
  parameter int NUM_SETS    = 8,
  parameter int OFFSET_BITS = 4,
  localparam int IDX_BITS   = $clog2(NUM_SETS),
  localparam int TAG_BITS   = 16 - IDX_BITS - OFFSET_BITS
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic [15:0]         mem_address,
  output logic                mem_resp,
  input  logic [TAG_BITS-1:0] stored_tag,
  output logic                data_write,
  output logic                tag_write,
  output logic                datain_sel,
  output logic                pmem_read,
  output logic                pmem_write,
  output logic [15:0]         pmem_address,
  input  logic                pmem_resp
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FILL      = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [NUM_SETS-1:0] valid_reg, valid_next;
  logic [NUM_SETS-1:0] dirty_reg, dirty_next;

  logic [IDX_BITS-1:0] index;
  logic [TAG_BITS-1:0] tag;
  logic                hit;
  logic                req;
  logic                write_hit;
  logic                wb_done;
  logic                fill_done;

  assign index     = mem_address[OFFSET_BITS +: IDX_BITS];
  assign tag       = mem_address[OFFSET_BITS + IDX_BITS +: TAG_BITS];
  assign hit       = valid_reg[index] && (stored_tag == tag);
  assign req       = mem_read || mem_write;
  // Write wins when both request lines are (illegally) high.
  assign write_hit = (state_reg == IDLE) && mem_write && hit;
  assign wb_done   = (state_reg == WRITEBACK) && pmem_resp;
  assign fill_done = (state_reg == FILL) && pmem_resp;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      valid_reg <= '0;
      dirty_reg <= '0;
    end else begin
      state_reg <= state_next;
      valid_reg <= valid_next;
      dirty_reg <= dirty_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SETS; gi++) begin : g_set
      logic sel;
      assign sel = (index == IDX_BITS'(gi));
      assign valid_next[gi] = (sel && fill_done) ? 1'b1 : valid_reg[gi];
      assign dirty_next[gi] = !sel                  ? dirty_reg[gi] :
                              (fill_done || wb_done) ? 1'b0 :
                              write_hit              ? 1'b1 : dirty_reg[gi];
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (req && !hit)
          state_next = (valid_reg[index] && dirty_reg[index]) ? WRITEBACK : FILL;
      end
      WRITEBACK: if (pmem_resp) state_next = FILL;
      FILL:      if (pmem_resp) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_resp     = 1'b0;
    data_write   = 1'b0;
    tag_write    = 1'b0;
    datain_sel   = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    case (state_reg)
      IDLE: begin
        if (mem_write && hit) begin
          data_write = 1'b1;
          mem_resp   = 1'b1;
        end else if (mem_read && hit) begin
          mem_resp = 1'b1;
        end
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {stored_tag, index, {OFFSET_BITS{1'b0}}};
      end
      FILL: begin
        pmem_read    = 1'b1;
        pmem_address = {tag, index, {OFFSET_BITS{1'b0}}};
        if (pmem_resp) begin
          data_write = 1'b1;
          tag_write  = 1'b1;
          datain_sel = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_control.sv
// Bench for cache_control: models the line arrays and physical memory around it,
// and compares CPU-visible data against a flat word-addressed reference memory.
module tb_cache_control;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [15:0] mem_address = '0;
  logic        mem_resp;
  logic [8:0]  stored_tag;
  logic        data_write;
  logic        tag_write;
  logic        datain_sel;
  logic        pmem_read;
  logic        pmem_write;
  logic [15:0] pmem_address;
  logic        pmem_resp;

  cache_control dut (
    .clk(clk), .reset_n(reset_n),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_resp(mem_resp), .stored_tag(stored_tag),
    .data_write(data_write), .tag_write(tag_write), .datain_sel(datain_sel),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  // Surroundings: line arrays, CPU write merge, physical memory with latency.
  logic [127:0] data_arr [8];
  logic [8:0]   tag_arr  [8];
  logic [127:0] pmem_mem [4096];
  logic [15:0]  mem_wdata = '0;
  logic [127:0] merged_line;
  logic [127:0] pmem_rdata;
  logic [2:0]   cur_idx;
  int           pmem_lat = 3;
  int           lat_cnt;

  assign cur_idx    = mem_address[6:4];
  assign stored_tag = tag_arr[cur_idx];
  assign pmem_rdata = pmem_mem[pmem_address[15:4]];

  always_comb begin
    merged_line = data_arr[cur_idx];
    merged_line[int'(mem_address[3:1])*16 +: 16] = mem_wdata;
  end

  always @(posedge clk) begin
    if (data_write) data_arr[cur_idx] <= datain_sel ? pmem_rdata : merged_line;
    if (tag_write)  tag_arr[cur_idx]  <= mem_address[15:7];
    if (pmem_resp && pmem_write) pmem_mem[pmem_address[15:4]] <= data_arr[cur_idx];
  end

  // pmem_resp is asserted in the pmem_lat-th cycle of a request (pmem_lat >= 2).
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lat_cnt   <= 0;
      pmem_resp <= 1'b0;
    end else begin
      pmem_resp <= 1'b0;
      if ((pmem_read || pmem_write) && !pmem_resp) begin
        if (lat_cnt + 1 >= pmem_lat - 1) begin
          pmem_resp <= 1'b1;
          lat_cnt   <= 0;
        end else begin
          lat_cnt <= lat_cnt + 1;
        end
      end
    end
  end

  // Reference model: flat word memory with a deterministic initial image.
  logic [15:0] ref_mem [logic [14:0]];

  function automatic logic [15:0] init_word(input logic [14:0] w);
    return 16'(w) ^ {w[6:0], 9'h0} ^ 16'hA5C3;
  endfunction

  function automatic logic [15:0] ref_read(input logic [15:0] a);
    if (ref_mem.exists(a[15:1])) return ref_mem[a[15:1]];
    return init_word(a[15:1]);
  endfunction

  int n_checks = 0;
  int n_bad    = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Per-transaction observations.
  bit          saw_rd, saw_wr, saw_fill, wb_before_rd, both_seen, resp_bad;
  logic [15:0] rd_addr, wr_addr;
  logic        first_dw, first_sel;

  task automatic do_access(input bit wr, input logic [15:0] addr, input logic [15:0] wd,
                           input int lat, output int cycles, output logic [15:0] rd);
    bit done;
    pmem_lat = lat;
    saw_rd = 0; saw_wr = 0; saw_fill = 0; wb_before_rd = 0;
    rd_addr = '0; wr_addr = '0; first_dw = 0; first_sel = 0;
    rd = '0;
    @(negedge clk);
    mem_address = addr;
    mem_wdata   = wd;
    mem_write   = wr;
    mem_read    = !wr;
    cycles = 0;
    done   = 0;
    while (!done && cycles < 100) begin
      #1;
      cycles++;
      if (pmem_read && pmem_write) both_seen = 1;
      if (mem_resp && (pmem_read || pmem_write)) resp_bad = 1;
      if (pmem_write && !saw_wr) begin saw_wr = 1; wr_addr = pmem_address; end
      if (pmem_read && !saw_rd) begin saw_rd = 1; rd_addr = pmem_address; wb_before_rd = saw_wr; end
      if (data_write && tag_write && datain_sel) saw_fill = 1;
      if (cycles == 1) begin first_dw = data_write; first_sel = datain_sel; end
      if (mem_resp) begin
        done = 1;
        rd = data_arr[addr[6:4]][int'(addr[3:1])*16 +: 16];
      end else begin
        @(negedge clk);
      end
    end
    if (!done) check_eq("resp_timeout", 32'(done), 32'd1);
    @(negedge clk);
    mem_read  = 1'b0;
    mem_write = 1'b0;
    $display("txn %s addr=%h data=%h cycles=%0d pmem_wr=%0d pmem_rd=%0d",
             wr ? "WR" : "RD", addr, wr ? wd : rd, cycles, saw_wr, saw_rd);
  endtask

  logic [8:0] tag_tab [4] = '{9'h024, 9'h0A5, 9'h101, 9'h1FF};

  initial begin
    int          cyc;
    logic [15:0] rd, addr, wd;
    bit          wr;

    both_seen = 0;
    resp_bad  = 0;
    for (int i = 0; i < 8; i++) begin data_arr[i] = '0; tag_arr[i] = '0; end
    for (int l = 0; l < 4096; l++)
      for (int k = 0; k < 8; k++)
        pmem_mem[l][k*16 +: 16] = init_word(15'(l*8 + k));

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_outputs", {26'b0, mem_resp, data_write, tag_write, datain_sel, pmem_read, pmem_write}, 32'd0);
    check_eq("rst_paddr", 32'(pmem_address), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // 1: cold read miss, 3-cycle memory
    do_access(0, 16'h1234, 16'h0, 3, cyc, rd);
    check_eq("t1_cycles", cyc, 5);
    check_eq("t1_pmem_rd", 32'(saw_rd), 1);
    check_eq("t1_rd_addr", 32'(rd_addr), 32'h1230);
    check_eq("t1_no_wb", 32'(saw_wr), 0);
    check_eq("t1_fill_strobes", 32'(saw_fill), 1);
    check_eq("t1_data", 32'(rd), 32'(ref_read(16'h1234)));

    // 2: same-line read hit
    do_access(0, 16'h1238, 16'h0, 3, cyc, rd);
    check_eq("t2_cycles", cyc, 1);
    check_eq("t2_no_pmem", 32'(saw_rd | saw_wr), 0);
    check_eq("t2_data", 32'(rd), 32'(ref_read(16'h1238)));

    // 3: write hit
    do_access(1, 16'h1230, 16'hBEEF, 3, cyc, rd);
    ref_mem[15'h1230 >> 1] = 16'hBEEF;
    check_eq("t3_cycles", cyc, 1);
    check_eq("t3_data_write", 32'(first_dw), 1);
    check_eq("t3_datain_sel", 32'(first_sel), 0);
    check_eq("t3_no_pmem", 32'(saw_rd | saw_wr), 0);

    // 4: conflicting read forces writeback of the dirty line
    do_access(0, 16'h5230, 16'h0, 2, cyc, rd);
    check_eq("t4_cycles", cyc, 6);
    check_eq("t4_wb_seen", 32'(saw_wr), 1);
    check_eq("t4_wb_addr", 32'(wr_addr), 32'h1230);
    check_eq("t4_rd_addr", 32'(rd_addr), 32'h5230);
    check_eq("t4_wb_first", 32'(wb_before_rd), 1);
    check_eq("t4_data", 32'(rd), 32'(ref_read(16'h5230)));
    do_access(0, 16'h1230, 16'h0, 2, cyc, rd);
    check_eq("t4_clean_no_wb", 32'(saw_wr), 0);
    check_eq("t4_wb_data", 32'(rd), 32'(ref_read(16'h1230)));

    // 5: reset in the middle of a fill
    pmem_lat = 20;
    @(negedge clk);
    mem_address = 16'h2340;
    mem_read    = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_eq("t5_in_fill", 32'(pmem_read), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("t5_async_drop", 32'(pmem_read), 0);
    check_eq("t5_paddr_zero", 32'(pmem_address), 0);
    mem_read = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    do_access(0, 16'h2340, 16'h0, 3, cyc, rd);
    check_eq("t5_remiss", 32'(saw_rd), 1);
    check_eq("t5_cycles", cyc, 5);
    check_eq("t5_data", 32'(rd), 32'(ref_read(16'h2340)));

    // 6: random traffic over 64 addresses
    for (int n = 0; n < 200; n++) begin
      addr = {tag_tab[$urandom_range(0, 3)], 3'($urandom_range(0, 7)),
              ($urandom_range(0, 1) != 0) ? 3'd5 : 3'd0, 1'b0};
      wr = ($urandom_range(0, 9) < 4);
      wd = 16'($urandom);
      do_access(wr, addr, wd, $urandom_range(2, 4), cyc, rd);
      if (wr) ref_mem[addr[15:1]] = wd;
      else    check_eq("t6_rd_data", 32'(rd), 32'(ref_read(addr)));
    end
    check_eq("pmem_rd_wr_exclusive", 32'(both_seen), 0);
    check_eq("no_resp_during_pmem", 32'(resp_bad), 0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
